pong_score: RTL

//  Score keeper and score-digit overlay for the pong playfield. Runs in the pixel_clock

---
 rtl/pong_score.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pong_score.sv
// Score keeper and digit overlay for the pong playfield: counts points once per frame,
// detects match end and renders both scores as scaled 3x5 glyphs on a registered pixel.
module pong_score #(
   parameter int WIN_SCORE  = 9,
   parameter int SCALE_LOG2 = 3,
   parameter int DIGIT0_X   = 392,
   parameter int DIGIT1_X   = 448,
   parameter int DIGIT_Y    = 59
) (
   input  logic       pixel_clock,
   input  logic       reset,
   input  logic [9:0] h_cnt,
   input  logic [9:0] v_cnt,
   input  logic       vga_vs,
   input  logic       game_running,
   input  logic       ball_exits_left,
   input  logic       ball_exits_right,
   input  logic       start,
   output logic [3:0] score_0,
   output logic [3:0] score_1,
   output logic       match_over,
   output logic       winner,
   output logic       score_pixel,
   output logic [1:0] fsm_state
);

   // Encoding is visible on fsm_state: IDLE=0, PLAY=1, SCORED=2, MATCH_OVER=3.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PLAY       = 2'd1,
      SCORED     = 2'd2,
      MATCH_OVER = 2'd3
   } state_t;

   localparam logic [3:0] WIN    = 4'(WIN_SCORE);
   localparam logic [9:0] D0_X   = 10'(DIGIT0_X);
   localparam logic [9:0] D1_X   = 10'(DIGIT1_X);
   localparam logic [9:0] D_Y    = 10'(DIGIT_Y);
   localparam logic [9:0] CELL_W = 10'(3 << SCALE_LOG2);
   localparam logic [9:0] CELL_H = 10'(5 << SCALE_LOG2);

   state_t     state_q, state_d;
   logic       vs_q;
   logic       frame_tick;
   logic       parity_q;
   logic [3:0] score_0_d, score_1_d;
   logic       winner_d;
   logic       show_0, show_1;
   logic       pixel_d;

   assign frame_tick = vga_vs & ~vs_q;
   assign match_over = (state_q == MATCH_OVER);
   assign fsm_state  = state_q;

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         state_q     <= IDLE;
         vs_q        <= 1'b1;
         parity_q    <= 1'b0;
         score_0     <= 4'd0;
         score_1     <= 4'd0;
         winner      <= 1'b0;
         score_pixel <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_q        <= vga_vs;
         parity_q    <= parity_q ^ frame_tick;
         score_0     <= score_0_d;
         score_1     <= score_1_d;
         winner      <= winner_d;
         score_pixel <= pixel_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      score_0_d = score_0;
      score_1_d = score_1;
      winner_d  = winner;
      if (frame_tick) begin
         case (state_q)
            IDLE: if (game_running) state_d = PLAY;
            PLAY: begin
               // A double exit is ambiguous, so it scores nothing and the rally continues.
               if (ball_exits_left ^ ball_exits_right) begin
                  if (ball_exits_left) begin
                     if (score_1 < WIN) score_1_d = score_1 + 4'd1;
                  end else begin
                     if (score_0 < WIN) score_0_d = score_0 + 4'd1;
                  end
                  state_d = SCORED;
               end else if (!ball_exits_left && !game_running) begin
                  state_d = IDLE;
               end
            end
            SCORED: begin
               if (!game_running) begin
                  if (score_0 == WIN || score_1 == WIN) begin
                     state_d  = MATCH_OVER;
                     winner_d = (score_1 == WIN);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            MATCH_OVER: begin
               if (start) begin
                  score_0_d = 4'd0;
                  score_1_d = 4'd0;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   function automatic logic [14:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 15'b111_101_101_101_111;
         4'd1:    glyph = 15'b010_110_010_010_111;
         4'd2:    glyph = 15'b111_001_111_100_111;
         4'd3:    glyph = 15'b111_001_111_001_111;
         4'd4:    glyph = 15'b101_101_111_001_001;
         4'd5:    glyph = 15'b111_100_111_001_111;
         4'd6:    glyph = 15'b111_100_111_101_111;
         4'd7:    glyph = 15'b111_001_001_001_001;
         4'd8:    glyph = 15'b111_101_111_101_111;
         4'd9:    glyph = 15'b111_101_111_001_111;
         default: glyph = 15'b0;
      endcase
   endfunction

   function automatic logic cell_lit(input logic [9:0] h, input logic [9:0] v,
                                     input logic [9:0] x0, input logic [3:0] d);
      logic [9:0]  dx, dy;
      logic [1:0]  col;
      logic [2:0]  row;
      logic [3:0]  idx;
      logic [15:0] g;
      dx  = h - x0;
      dy  = v - D_Y;
      col = 2'(dx >> SCALE_LOG2);
      row = 3'(dy >> SCALE_LOG2);
      idx = 4'(row) * 4'd3 + 4'(col);
      // Padded to 16 bits so any 4-bit index stays in range outside the digit box.
      g   = {glyph(d), 1'b0};
      cell_lit = (h >= x0) && (dx < CELL_W) && (v >= D_Y) && (dy < CELL_H) && g[4'd15 - idx];
   endfunction

   // Loser digit blinks during the match-over display; winner stays steady.
   assign show_0 = !(match_over && winner && parity_q);
   assign show_1 = !(match_over && !winner && parity_q);

   always_comb begin
      pixel_d = (show_0 && cell_lit(h_cnt, v_cnt, D0_X, score_0)) ||
                (show_1 && cell_lit(h_cnt, v_cnt, D1_X, score_1));
   end

endmodule
